// File: rtl/step_control.sv
// ---------------------------------------------------------------------------
// step_control
//
// Front-end clock-enable generator for the CPU datapath. It owns the operator
// controls for CPU clocking. It emits exactly one single-cycle o_cpuClkEn
// pulse per CPU microcycle, in one of three ways: free run, single-microcycle
// step, or single-instruction step (burst). It stops on breakpoint or halt
// feedback from the datapath.
//
// Parameters:
//   DEBOUNCE_CYCLES   stable oszClk cycles needed to accept a button change
//   RUN_DIV           run mode issues one enable every RUN_DIV oszClk cycles
//
// Ports:
//   i_oszClk              board oscillator clock, the only clock
//   i_reset               asynchronous active-high reset
//   i_btnStep             raw bouncing step button, 1 = closed
//   i_swInstrNCycle       1 = step whole instruction, 0 = step one microcycle
//   i_swStepNRun          1 = step mode, 0 = run mode
//   i_swEnableBreakpoint  1 = honour i_breakpointHit
//   i_instrDone           datapath: current microcycle ends its instruction
//   i_breakpointHit       datapath: current instruction is breakpoint-flagged
//   i_halt                datapath: halt instruction executing
//   o_cpuClkEn            registered single-cycle datapath enable
//   o_running             1 while in RUN or BURST
//   o_stopped             1 while in BREAK or HALT
// ---------------------------------------------------------------------------
module step_control #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int RUN_DIV         = 1
) (
    input  logic i_oszClk,
    input  logic i_reset,
    input  logic i_btnStep,
    input  logic i_swInstrNCycle,
    input  logic i_swStepNRun,
    input  logic i_swEnableBreakpoint,
    input  logic i_instrDone,
    input  logic i_breakpointHit,
    input  logic i_halt,
    output logic o_cpuClkEn,
    output logic o_running,
    output logic o_stopped
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int DIV_W = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(RUN_DIV - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_BURST,
        ST_BREAK,
        ST_HALT
    } state_t;

    // Two-stage synchronisers for every input except reset.
    logic [6:0] rawIn;
    logic [6:0] sync1_q;
    logic [6:0] sync2_q;

    logic btnSync;
    logic instrModeSync;
    logic stepModeSync;
    logic enBpSync;
    logic instrDoneSync;
    logic bpHitSync;
    logic haltSync;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             btnLevel_q, btnLevel_d;
    logic             stepReq;

    state_t           state_q, state_d;
    logic             cpuClkEn_q, cpuClkEn_d;
    logic [DIV_W-1:0] divCnt_q, divCnt_d;
    logic             bpArmed_q, bpArmed_d;

    logic haltHit;
    logic doneHit;
    logic bpBreak;

    assign rawIn = {i_btnStep, i_swInstrNCycle, i_swStepNRun, i_swEnableBreakpoint,
                    i_instrDone, i_breakpointHit, i_halt};

    assign btnSync       = sync2_q[6];
    assign instrModeSync = sync2_q[5];
    assign stepModeSync  = sync2_q[4];
    assign enBpSync      = sync2_q[3];
    assign instrDoneSync = sync2_q[2];
    assign bpHitSync     = sync2_q[1];
    assign haltSync      = sync2_q[0];

    always_ff @(posedge i_oszClk or posedge i_reset) begin
        if (i_reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= rawIn;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: the counter only advances while the synchronised button
    // disagrees with the accepted level, so any bounce back restarts it.
    // The step request fires in the same cycle the level rises.
    always_comb begin
        cnt_d      = '0;
        btnLevel_d = btnLevel_q;
        stepReq    = 1'b0;
        if (btnSync != btnLevel_q) begin
            if (cnt_q == CNT_MAX) begin
                btnLevel_d = btnSync;
                stepReq    = btnSync;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge i_oszClk or posedge i_reset) begin
        if (i_reset) begin
            cnt_q      <= '0;
            btnLevel_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            btnLevel_q <= btnLevel_d;
        end
    end

    // Datapath feedback is meaningful only while a pulse is being executed.
    assign haltHit = cpuClkEn_q && haltSync;
    assign doneHit = cpuClkEn_q && instrDoneSync;
    assign bpBreak = cpuClkEn_q && bpHitSync && enBpSync && bpArmed_q;

    // Next-state logic. Halt is checked before breakpoint so that it wins
    // when both arrive together. An enable already registered always
    // completes its cycle; decisions here only affect the next pulse.
    always_comb begin
        state_d    = state_q;
        cpuClkEn_d = 1'b0;
        divCnt_d   = divCnt_q;
        bpArmed_d  = bpArmed_q;

        if (doneHit) begin
            bpArmed_d = 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (haltHit) begin
                    state_d = ST_HALT;
                end else if (!stepModeSync) begin
                    state_d  = ST_RUN;
                    divCnt_d = '0;
                end else if (stepReq) begin
                    if (instrModeSync) begin
                        state_d = ST_BURST;
                    end else begin
                        cpuClkEn_d = 1'b1;
                    end
                end
            end

            ST_BURST: begin
                if (haltHit) begin
                    state_d = ST_HALT;
                end else if (doneHit) begin
                    state_d = ST_IDLE;
                end else begin
                    cpuClkEn_d = 1'b1;
                end
            end

            ST_RUN: begin
                if (haltHit) begin
                    state_d = ST_HALT;
                end else if (bpBreak) begin
                    state_d = ST_BREAK;
                end else if (stepModeSync) begin
                    state_d = ST_IDLE;
                end else if (divCnt_q == DIV_MAX) begin
                    cpuClkEn_d = 1'b1;
                    divCnt_d   = '0;
                end else begin
                    divCnt_d = divCnt_q + DIV_W'(1);
                end
            end

            // Resuming disarms the breakpoint so the rest of the flagged
            // instruction runs through; its final microcycle re-arms it.
            ST_BREAK: begin
                if (stepReq) begin
                    bpArmed_d = 1'b0;
                    if (!stepModeSync) begin
                        state_d  = ST_RUN;
                        divCnt_d = '0;
                    end else if (instrModeSync) begin
                        state_d = ST_BURST;
                    end else begin
                        state_d    = ST_IDLE;
                        cpuClkEn_d = 1'b1;
                    end
                end else if (stepModeSync) begin
                    state_d = ST_IDLE;
                end
            end

            ST_HALT: begin
                state_d = ST_HALT;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_oszClk or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= ST_IDLE;
            cpuClkEn_q <= 1'b0;
            divCnt_q   <= '0;
            bpArmed_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            cpuClkEn_q <= cpuClkEn_d;
            divCnt_q   <= divCnt_d;
            bpArmed_q  <= bpArmed_d;
        end
    end

    assign o_cpuClkEn = cpuClkEn_q;
    assign o_running  = (state_q == ST_RUN) || (state_q == ST_BURST);
    assign o_stopped  = (state_q == ST_BREAK) || (state_q == ST_HALT);

endmodule

// File: tb/tb_step_control.sv
// ---------------------------------------------------------------------------
// tb_step_control
//
// Directed bench for step_control (DEBOUNCE_CYCLES=4, RUN_DIV=2). A small
// datapath model drives the feedback inputs from per-pulse program tables.
// The stimulus process pushes the pulses it expects into a scoreboard queue,
// and a monitor pops one entry for every o_cpuClkEn pulse it sees.
// ---------------------------------------------------------------------------
module tb_step_control;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset;
    logic btnStep;
    logic swInstrNCycle;
    logic swStepNRun;
    logic swEnableBreakpoint;
    logic instrDone;
    logic breakpointHit;
    logic halt;
    logic cpuClkEn;
    logic running;
    logic stopped;

    int checkCount = 0;
    int failCount  = 0;
    int pulseCount = 0;
    int lookahead  = 1;
    bit sbEnable   = 1'b0;

    bit progDone [64];
    bit progBp   [64];
    bit progHalt [64];

    typedef struct packed {
        logic running;
        logic stopped;
    } expect_t;

    expect_t sbQueue [$];

    step_control #(
        .DEBOUNCE_CYCLES(4),
        .RUN_DIV        (2)
    ) dut (
        .i_oszClk            (clock),
        .i_reset             (reset),
        .i_btnStep           (btnStep),
        .i_swInstrNCycle     (swInstrNCycle),
        .i_swStepNRun        (swStepNRun),
        .i_swEnableBreakpoint(swEnableBreakpoint),
        .i_instrDone         (instrDone),
        .i_breakpointHit     (breakpointHit),
        .i_halt              (halt),
        .o_cpuClkEn          (cpuClkEn),
        .o_running           (running),
        .o_stopped           (stopped)
    );

    // Shared comparison helper used by stimulus and monitor alike.
    task automatic checkOutput(input string name, input int actual, input int expected);
        checkCount++;
        if (actual != expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Advance n cycles, landing 2 time units after the rising edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #2;
        end
    endtask

    task automatic applyStimulus(input logic instrMode, input logic stepMode, input logic enBp);
        swInstrNCycle      = instrMode;
        swStepNRun         = stepMode;
        swEnableBreakpoint = enBp;
    endtask

    task automatic clearProgram();
        for (int i = 0; i < 64; i++) begin
            progDone[i] = 1'b0;
            progBp[i]   = 1'b0;
            progHalt[i] = 1'b0;
        end
    endtask

    // Present the first microcycle's feedback before any pulse occurs.
    task automatic loadProgram(input int ahead);
        lookahead     = ahead;
        pulseCount    = 0;
        instrDone     = progDone[1];
        breakpointHit = progBp[1];
        halt          = progHalt[1];
    endtask

    task automatic pressButton(input int bounces);
        for (int b = 0; b < bounces; b++) begin
            btnStep = 1'b1;
            tick(2);
            btnStep = 1'b0;
            tick(2);
        end
        btnStep = 1'b1;
        tick(10);
        btnStep = 1'b0;
        tick(10);
    endtask

    task automatic waitDrain(input string name, input int budget);
        int n = 0;
        while (sbQueue.size() != 0 && n < budget) begin
            tick(1);
            n++;
        end
        checkOutput(name, sbQueue.size(), 0);
    endtask

    task automatic waitPulses(input string name, input int target, input int budget);
        int n = 0;
        while (pulseCount < target && n < budget) begin
            tick(1);
            n++;
        end
        checkOutput(name, int'(pulseCount >= target), 1);
    endtask

    task automatic waitStopped(input string name, input int budget);
        int n = 0;
        while (stopped !== 1'b1 && n < budget) begin
            tick(1);
            n++;
        end
        checkOutput(name, int'(stopped), 1);
    endtask

    // Datapath model and monitor. On each pulse the feedback inputs are
    // updated for the microcycle executed `lookahead` pulses later, which
    // compensates for the input synchroniser latency.
    initial begin
        int idx;
        expect_t e;
        forever begin
            @(posedge clock);
            #1;
            if (cpuClkEn === 1'b1) begin
                pulseCount++;
                idx = pulseCount + lookahead;
                if (idx < 64) begin
                    instrDone     = progDone[idx];
                    breakpointHit = progBp[idx];
                    halt          = progHalt[idx];
                end
                if (sbEnable) begin
                    checkOutput("pulseExpected", int'(sbQueue.size() > 0), 1);
                    if (sbQueue.size() > 0) begin
                        e = sbQueue.pop_front();
                        checkOutput("pulseRunning", int'(running), int'(e.running));
                        checkOutput("pulseStopped", int'(stopped), int'(e.stopped));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int c0;
        reset   = 1'b1;
        btnStep = 1'b0;
        applyStimulus(1'b0, 1'b1, 1'b0);
        clearProgram();
        loadProgram(1);

        // Reset state
        tick(3);
        checkOutput("resetClkEn", int'(cpuClkEn), 0);
        checkOutput("resetRunning", int'(running), 0);
        checkOutput("resetStopped", int'(stopped), 0);
        reset = 1'b0;
        tick(6);
        checkOutput("idleRunning", int'(running), 0);
        checkOutput("idlePulses", pulseCount, 0);

        // Single microcycle step through a bouncing press
        $display("[TB] single-cycle step with bounces");
        pulseCount = 0;
        sbEnable   = 1'b1;
        sbQueue.push_back('{running: 1'b0, stopped: 1'b0});
        pressButton(3);
        tick(5);
        waitDrain("cycleStepDrain", 20);
        checkOutput("cycleStepCount", pulseCount, 1);

        // Instruction step: instrDone on the 4th pulse
        $display("[TB] instruction burst of 4");
        applyStimulus(1'b1, 1'b1, 1'b0);
        clearProgram();
        progDone[4] = 1'b1;
        tick(4);
        loadProgram(2);
        for (int i = 0; i < 4; i++) begin
            sbQueue.push_back('{running: 1'b1, stopped: 1'b0});
        end
        pressButton(0);
        waitDrain("burstDrain", 30);
        tick(4);
        checkOutput("burstCount", pulseCount, 4);
        checkOutput("burstEndRunning", int'(running), 0);
        sbEnable = 1'b0;

        // Free run with divide-by-2, then back to step mode
        $display("[TB] free run");
        clearProgram();
        loadProgram(1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        tick(8);
        checkOutput("runRunning", int'(running), 1);
        c0 = pulseCount;
        tick(20);
        checkOutput("runPulsesIn20", pulseCount - c0, 10);
        applyStimulus(1'b1, 1'b1, 1'b0);
        tick(4);
        c0 = pulseCount;
        tick(16);
        checkOutput("runStopPulses", pulseCount - c0, 0);
        checkOutput("runStopRunning", int'(running), 0);

        // Breakpoint on a 3-microcycle instruction (pulses 4..6)
        $display("[TB] breakpoint enabled");
        clearProgram();
        for (int k = 3; k < 64; k += 3) progDone[k] = 1'b1;
        for (int k = 4; k <= 6; k++) progBp[k] = 1'b1;
        loadProgram(1);
        applyStimulus(1'b1, 1'b0, 1'b1);
        waitStopped("bpStopped", 100);
        checkOutput("bpPulseCount", pulseCount, 4);
        checkOutput("bpRunning", int'(running), 0);
        tick(10);
        checkOutput("bpHeld", pulseCount, 4);
        pressButton(0);
        waitPulses("bpResumeReach12", 12, 100);
        checkOutput("bpResumeStopped", int'(stopped), 0);
        checkOutput("bpResumeRunning", int'(running), 1);
        applyStimulus(1'b1, 1'b1, 1'b1);
        tick(10);
        checkOutput("bpEndRunning", int'(running), 0);

        // Same program with breakpoints disabled
        $display("[TB] breakpoint disabled");
        loadProgram(1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitPulses("noBpReach12", 12, 100);
        checkOutput("noBpStopped", int'(stopped), 0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        tick(10);

        // Halt on pulse 3 in run mode; step presses ignored
        $display("[TB] halt");
        clearProgram();
        progHalt[3] = 1'b1;
        loadProgram(1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitStopped("haltStopped", 60);
        checkOutput("haltPulseCount", pulseCount, 3);
        checkOutput("haltRunning", int'(running), 0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        pressButton(0);
        checkOutput("haltIgnoreStep", pulseCount, 3);
        checkOutput("haltStillStopped", int'(stopped), 1);

        // Reset out of HALT, then reset in the middle of a burst
        $display("[TB] reset mid-burst");
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(6);
        checkOutput("haltResetStopped", int'(stopped), 0);
        checkOutput("haltResetRunning", int'(running), 0);
        clearProgram();
        applyStimulus(1'b1, 1'b1, 1'b0);
        tick(4);
        loadProgram(2);
        btnStep = 1'b1;
        waitPulses("burstStarted", 3, 30);
        @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        checkOutput("midResetClkEn", int'(cpuClkEn), 0);
        checkOutput("midResetRunning", int'(running), 0);
        checkOutput("midResetStopped", int'(stopped), 0);
        btnStep = 1'b0;
        tick(3);
        reset = 1'b0;
        c0 = pulseCount;
        tick(12);
        checkOutput("postResetPulses", pulseCount - c0, 0);
        checkOutput("postResetRunning", int'(running), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
